mem_rd_arbiter: RTL

- Round-robin arbiter and read sequencer for the single shared 64-bit coefficient/key memory read port of the PQC core.
- Up to NREQ datapath clients (NTT, sampler, hash, debug readback) issue addressed read requests. The block grants one per cycle and drives the memory port.
- It tracks each in-flight read through the fixed RD_LAT-cycle memory latency and returns the data to the originating requester with a one-hot valid.

---
 rtl/mem_rd_arbiter_if.sv | 39 +++
 rtl/mem_rd_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter_if.sv
// Request/grant, shared memory read port and return bus of mem_rd_arbiter.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface mem_rd_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 10,
   parameter int unsigned DW   = 64
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ-1:0]    gnt;
   logic               mem_busy;
   logic               mem_re;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_rdata;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;
   logic [2:0]         outstanding;
`ifdef ARB_LOCK_EN
   logic [NREQ-1:0]    lock;
`endif

   // Requesters plus memory model side.
   modport master (
`ifdef ARB_LOCK_EN
      output lock,
`endif
      output req, req_addr, mem_busy, mem_rdata,
      input  gnt, mem_re, mem_addr, rvalid, rdata, outstanding
   );

   // Arbiter side.
   modport slave (
`ifdef ARB_LOCK_EN
      input  lock,
`endif
      input  req, req_addr, mem_busy, mem_rdata,
      output gnt, mem_re, mem_addr, rvalid, rdata, outstanding
   );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter and fixed-latency read sequencer for the shared coefficient/key memory port.
// Optional burst locking of the grant is compiled in with ARB_LOCK_EN.
module mem_rd_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned AW       = 10,
   parameter int unsigned DW       = 64,
   parameter int unsigned RD_LAT   = 3,
   parameter int unsigned MAX_LOCK = 16
) (
   input logic             clk,
   input logic             rst_all,
   mem_rd_arbiter_if.slave bus
);
   localparam int unsigned IDW = 3;

   if (NREQ < 2 || NREQ > 8 || RD_LAT < 1 || RD_LAT > 7 || MAX_LOCK < 1) begin : g_param_err
      $error("mem_rd_arbiter: parameter out of supported range");
   end

   logic [IDW-1:0]  r_rr_ptr;
   logic [IDW-1:0]  w_rr_ptr_d;
   logic [IDW-1:0]  w_sel;
   logic [IDW-1:0]  w_sel_next;
   logic            w_any;
   logic [NREQ-1:0] w_gnt;
   logic [AW-1:0]   w_addr;
   logic [RD_LAT-1:0] r_vld;
   logic [IDW-1:0]    r_id [RD_LAT];

`ifdef ARB_LOCK_EN
   localparam int unsigned LCW = $clog2(MAX_LOCK + 1);
   logic [LCW-1:0] r_lock_cnt;
   logic [LCW-1:0] w_lock_cnt_d;
   logic [LCW-1:0] w_lock_base;
   logic           w_lock_hold;
`endif

   // Winner is the requester at the smallest wrapped distance from the pointer.
   always_comb begin : arb
      int best_d;
      int d;
      best_d = int'(NREQ);
      d      = 0;
      w_sel  = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         d = i - int'(r_rr_ptr);
         if (d < 0) d += int'(NREQ);
         if (bus.req[i] && d < best_d) begin
            best_d = d;
            w_sel  = IDW'(i);
         end
      end
      w_any  = !rst_all && !bus.mem_busy && (best_d < int'(NREQ));
      w_gnt  = '0;
      w_addr = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (w_any && w_sel == IDW'(i)) begin
            w_gnt[i] = 1'b1;
            w_addr   = bus.req_addr[i*AW +: AW];
         end
      end
      w_sel_next = (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + IDW'(1);
   end

   assign bus.gnt      = w_gnt;
   assign bus.mem_re   = w_any;
   assign bus.mem_addr = w_addr;

   always_comb begin : ptr_next
      w_rr_ptr_d = r_rr_ptr;
`ifdef ARB_LOCK_EN
      w_lock_cnt_d = r_lock_cnt;
      w_lock_hold  = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (r_rr_ptr == IDW'(i) && bus.req[i] && bus.lock[i]) w_lock_hold = 1'b1;
      end
      // A locked winner other than the current holder starts a fresh burst.
      w_lock_base = (w_sel == r_rr_ptr) ? r_lock_cnt : '0;
      if (w_any) begin
         if ((w_gnt & bus.lock) != '0) begin
            if (w_lock_base == LCW'(MAX_LOCK - 1)) begin
               w_rr_ptr_d   = w_sel_next;
               w_lock_cnt_d = '0;
            end else begin
               w_rr_ptr_d   = w_sel;
               w_lock_cnt_d = w_lock_base + LCW'(1);
            end
         end else begin
            w_rr_ptr_d   = w_sel_next;
            w_lock_cnt_d = '0;
         end
      end else if (!w_lock_hold) begin
         w_lock_cnt_d = '0;
      end
`else
      if (w_any) w_rr_ptr_d = w_sel_next;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst_all) begin
         r_rr_ptr <= '0;
         r_vld    <= '0;
         for (int s = 0; s < int'(RD_LAT); s++) r_id[s] <= '0;
`ifdef ARB_LOCK_EN
         r_lock_cnt <= '0;
`endif
      end else begin
         r_rr_ptr <= w_rr_ptr_d;
         r_vld[0] <= w_any;
         r_id[0]  <= w_sel;
         for (int s = 1; s < int'(RD_LAT); s++) begin
            r_vld[s] <= r_vld[s-1];
            r_id[s]  <= r_id[s-1];
         end
`ifdef ARB_LOCK_EN
         r_lock_cnt <= w_lock_cnt_d;
`endif
      end
   end

   // The last tracking stage lines up with mem_rdata for the read it carries.
   always_comb begin : ret
      bus.rvalid      = '0;
      bus.rdata       = '0;
      bus.outstanding = '0;
      if (!rst_all) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            bus.rvalid[i] = r_vld[RD_LAT-1] && (r_id[RD_LAT-1] == IDW'(i));
         end
         if (r_vld[RD_LAT-1]) bus.rdata = bus.mem_rdata;
         for (int s = 0; s < int'(RD_LAT); s++) begin
            bus.outstanding = bus.outstanding + 3'(r_vld[s]);
         end
      end
   end
endmodule
